// File: rtl/rx_frame_filter.sv
// rx_frame_filter: store-and-forward RX filter that releases only complete, good MAC frames
// Ports:
//   clk156, reset                      clock and synchronous active-high reset
//   s_axis_tdata/tkeep/tvalid/tlast    MAC RX stream; no backpressure
//   s_axis_tuser                       frame status on the tlast beat (1 = good)
//   m_axis_tdata/tkeep/tvalid/tlast    filtered output stream
//   m_axis_tready                      downstream backpressure
//   good_frames/bad_frames             committed / bad-FCS frame counts (wrapping)
//   overflow_frames                    frames dropped because the buffer was full (wrapping)
module rx_frame_filter #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [31:0] good_frames,
    output logic [31:0] bad_frames,
    output logic [31:0] overflow_frames
);
    typedef enum logic {PASS, DROP} state_t;
    localparam logic [ADDR_W:0] ONE = 1;
    state_t state, state_n;
    logic [72:0] mem [DEPTH];
    logic [72:0] mem_q;
    logic [72:0] ob [2];
    logic [ADDR_W:0] wr_ptr, wr_commit, rd_ptr;
    logic full, wr_en, cnt_good, cnt_bad, cnt_ovf;
    logic rd_en, rd_vld, pop, widx;
    logic [1:0] cnt, occ;
    // Full is judged against the registered rd_ptr, so it may be one read pessimistic.
    assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        cnt_good = 1'b0;
        cnt_bad  = 1'b0;
        cnt_ovf  = 1'b0;
        if (s_axis_tvalid) begin
            if (state == PASS) begin
                wr_en    = !full;
                cnt_good = !full && s_axis_tlast && s_axis_tuser;
                cnt_bad  = !full && s_axis_tlast && !s_axis_tuser;
                cnt_ovf  = full;
                state_n  = (full && !s_axis_tlast) ? DROP : PASS;
            end else begin
                state_n = s_axis_tlast ? PASS : DROP;
            end
        end
    end
    always_ff @(posedge clk156) begin
        if (reset) begin
            state           <= PASS;
            wr_ptr          <= '0;
            wr_commit       <= '0;
            good_frames     <= '0;
            bad_frames      <= '0;
            overflow_frames <= '0;
        end else begin
            state           <= state_n;
            // Bad or overflowing frames roll back to the last commit point.
            wr_ptr          <= (cnt_bad || cnt_ovf) ? wr_commit : wr_en ? wr_ptr + ONE : wr_ptr;
            wr_commit       <= cnt_good ? wr_ptr + ONE : wr_commit;
            good_frames     <= good_frames + 32'(cnt_good);
            bad_frames      <= bad_frames + 32'(cnt_bad);
            overflow_frames <= overflow_frames + 32'(cnt_ovf);
        end
    end
    always_ff @(posedge clk156) begin
        if (wr_en)
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (rd_en)
            mem_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
    // Output buffer occupancy after this edge, including the read already in flight.
    assign pop   = (cnt != 2'd0) && m_axis_tready;
    assign occ   = cnt + {1'b0, rd_vld} - {1'b0, pop};
    assign rd_en = (rd_ptr != wr_commit) && (occ < 2'd2);
    assign widx  = pop ? (cnt == 2'd2) : (cnt != 2'd0);
    always_ff @(posedge clk156) begin
        if (reset) begin
            rd_ptr <= '0;
            rd_vld <= 1'b0;
            cnt    <= '0;
            ob[0]  <= '0;
            ob[1]  <= '0;
        end else begin
            rd_ptr <= rd_en ? rd_ptr + ONE : rd_ptr;
            rd_vld <= rd_en;
            cnt    <= occ;
            if (pop)
                ob[0] <= ob[1];
            if (rd_vld)
                ob[widx] <= mem_q;
        end
    end
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = ob[0];
    assign m_axis_tvalid = cnt != 2'd0;
endmodule

// File: tb/tb_rx_frame_filter.sv
// tb_rx_frame_filter: self-checking bench for rx_frame_filter (default depth and DEPTH=16 instances)
module tb_rx_frame_filter;
    typedef struct {
        logic [72:0] b;
        int          c;
    } rec_t;

    logic        clk156 = 1'b0;
    logic        reset;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tuser, m_tready, sel;
    logic [63:0] a_tdata, b_tdata;
    logic [7:0]  a_tkeep, b_tkeep;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast;
    logic [31:0] a_good, a_bad, a_ovf, b_good, b_bad, b_ovf;
    logic [72:0] o_beat;
    logic        o_tvalid;
    logic [31:0] o_good, o_bad, o_ovf;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   last_cyc;
    rec_t exp_q[$];
    rec_t rx_q[$];
    int   r_len, r_good_sent, r_bad_sent, r_budget;
    bit   r_g, r_done, r_stop, r_expv, r_prev_stall;
    logic [72:0] r_prev_beat;

    always #5 clk156 = ~clk156;
    always @(posedge clk156) cyc++;

    rx_frame_filter dut (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
        .m_axis_tlast(a_tlast), .m_axis_tready(m_tready),
        .good_frames(a_good), .bad_frames(a_bad), .overflow_frames(a_ovf)
    );

    rx_frame_filter #(.DEPTH(16)) dut_s (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
        .m_axis_tlast(b_tlast), .m_axis_tready(m_tready),
        .good_frames(b_good), .bad_frames(b_bad), .overflow_frames(b_ovf)
    );

    assign o_beat   = sel ? {b_tlast, b_tkeep, b_tdata} : {a_tlast, a_tkeep, a_tdata};
    assign o_tvalid = sel ? b_tvalid : a_tvalid;
    assign o_good   = sel ? b_good : a_good;
    assign o_bad    = sel ? b_bad : a_bad;
    assign o_ovf    = sel ? b_ovf : a_ovf;

    task automatic do_reset();
        reset = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk156);
        reset = 1'b0;
    endtask

    // Drives one frame on consecutive cycles; good frames optionally go to the expected queue,
    // becoming visible at the edge that accepts their tlast beat.
    task automatic send_frame(input int len, input bit good, input bit rnd,
                              input logic [63:0] base, input logic [7:0] lkeep, input bit model);
        logic [72:0] fr[$];
        for (int i = 0; i < len; i++) begin
            s_tdata  = rnd ? {$urandom, $urandom} : base + 64'(i);
            s_tkeep  = rnd ? 8'($urandom) : (i == len - 1 ? lkeep : 8'hFF);
            s_tlast  = (i == len - 1);
            s_tuser  = (i == len - 1) ? good : 1'($urandom);
            s_tvalid = 1'b1;
            fr.push_back({s_tlast, s_tkeep, s_tdata});
            if (s_tlast) begin
                last_cyc = cyc;
                if (model && good)
                    foreach (fr[j]) exp_q.push_back('{fr[j], cyc + 1});
            end
            @(negedge clk156);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (o_tvalid && m_tready)
                rx_q.push_back('{o_beat, cyc});
            @(negedge clk156);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            checks++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid dut%0d: got %b want 0", k, o_tvalid); end
            checks++; if (o_beat !== 73'd0) begin fails++; $display("FAIL reset_beat dut%0d: got %h want 0", k, o_beat); end
            checks++; if (o_good !== 32'd0) begin fails++; $display("FAIL reset_good dut%0d: got %0d want 0", k, o_good); end
            checks++; if (o_bad !== 32'd0) begin fails++; $display("FAIL reset_bad dut%0d: got %0d want 0", k, o_bad); end
            checks++; if (o_ovf !== 32'd0) begin fails++; $display("FAIL reset_ovf dut%0d: got %0d want 0", k, o_ovf); end
        end
        @(negedge clk156);
    endtask

    task automatic test_good_frame();
        logic [72:0] e;
        sel = 1'b0; m_tready = 1'b1;
        do_reset();
        rx_q.delete();
        send_frame(8, 1'b1, 1'b0, 64'h1, 8'h0F, 1'b0);
        collect(20);
        checks++; if (rx_q.size() != 8) begin fails++; $display("FAIL good_count: got %0d want 8", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            e = {i == 7, (i == 7) ? 8'h0F : 8'hFF, 64'(i + 1)};
            checks++; if (rx_q[i].b !== e) begin fails++; $display("FAIL good_beat%0d: got %h want %h", i, rx_q[i].b, e); end
        end
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0].c != last_cyc + 3) begin fails++; $display("FAIL good_latency: got cycle %0d want %0d", rx_q[0].c, last_cyc + 3); end
            checks++; if (rx_q[rx_q.size()-1].c - rx_q[0].c != rx_q.size() - 1) begin fails++; $display("FAIL good_bubble: span %0d want %0d", rx_q[rx_q.size()-1].c - rx_q[0].c, rx_q.size() - 1); end
        end
        checks++; if (o_good !== 32'd1) begin fails++; $display("FAIL good_frames: got %0d want 1", o_good); end
        checks++; if (o_bad !== 32'd0) begin fails++; $display("FAIL good_bad_frames: got %0d want 0", o_bad); end
    endtask

    task automatic test_bad_then_good();
        logic [72:0] e;
        sel = 1'b0; m_tready = 1'b1;
        do_reset();
        rx_q.delete();
        send_frame(5, 1'b0, 1'b0, 64'hB0, 8'hFF, 1'b0);
        send_frame(3, 1'b1, 1'b0, 64'hC0, 8'h03, 1'b0);
        collect(20);
        checks++; if (rx_q.size() != 3) begin fails++; $display("FAIL bad_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            e = {i == 2, (i == 2) ? 8'h03 : 8'hFF, 64'hC0 + 64'(i)};
            checks++; if (rx_q[i].b !== e) begin fails++; $display("FAIL bad_beat%0d: got %h want %h", i, rx_q[i].b, e); end
        end
        checks++; if (o_bad !== 32'd1) begin fails++; $display("FAIL bad_frames: got %0d want 1", o_bad); end
        checks++; if (o_good !== 32'd1) begin fails++; $display("FAIL bad_good_frames: got %0d want 1", o_good); end
    endtask

    task automatic test_overflow();
        logic [72:0] e;
        sel = 1'b1; m_tready = 1'b0;
        do_reset();
        send_frame(10, 1'b1, 1'b0, 64'h100, 8'hFF, 1'b0);
        send_frame(10, 1'b1, 1'b0, 64'h200, 8'h0F, 1'b0);
        repeat (3) @(negedge clk156);
        checks++; if (o_ovf !== 32'd1) begin fails++; $display("FAIL ovf_frames: got %0d want 1", o_ovf); end
        checks++; if (o_good !== 32'd1) begin fails++; $display("FAIL ovf_good_frames: got %0d want 1", o_good); end
        e = {1'b0, 8'hFF, 64'h100};
        checks++; if (o_tvalid !== 1'b1 || o_beat !== e) begin fails++; $display("FAIL ovf_hold: got v=%b %h want v=1 %h", o_tvalid, o_beat, e); end
        m_tready = 1'b1;
        rx_q.delete();
        collect(30);
        checks++; if (rx_q.size() != 10) begin fails++; $display("FAIL ovf_count: got %0d want 10", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 10; i++) begin
            e = {i == 9, 8'hFF, 64'h100 + 64'(i)};
            checks++; if (rx_q[i].b !== e) begin fails++; $display("FAIL ovf_beat%0d: got %h want %h", i, rx_q[i].b, e); end
        end
    endtask

    task automatic test_long_frame();
        logic [72:0] e;
        sel = 1'b1; m_tready = 1'b1;
        do_reset();
        rx_q.delete();
        send_frame(20, 1'b1, 1'b0, 64'h300, 8'hFF, 1'b0);
        send_frame(1, 1'b1, 1'b0, 64'h400, 8'h03, 1'b0);
        collect(10);
        checks++; if (o_ovf !== 32'd1) begin fails++; $display("FAIL long_ovf: got %0d want 1", o_ovf); end
        checks++; if (o_good !== 32'd1) begin fails++; $display("FAIL long_good: got %0d want 1", o_good); end
        checks++; if (rx_q.size() != 1) begin fails++; $display("FAIL long_count: got %0d want 1", rx_q.size()); end
        e = {1'b1, 8'h03, 64'h400};
        if (rx_q.size() > 0) begin
            checks++; if (rx_q[0].b !== e) begin fails++; $display("FAIL long_beat: got %h want %h", rx_q[0].b, e); end
        end
    endtask

    task automatic test_random();
        sel = 1'b0; m_tready = 1'b0;
        do_reset();
        exp_q.delete();
        r_good_sent = 0; r_bad_sent = 0; r_done = 1'b0; r_stop = 1'b0;
        fork
            begin
                while (r_good_sent < 100 && !r_stop) begin
                    r_len = $urandom_range(1, 64);
                    r_g = $urandom_range(0, 7) != 0;
                    // Keep outstanding data well below the buffer size so no frame overflows.
                    while (exp_q.size() + r_len > 440 && !r_stop) @(negedge clk156);
                    send_frame(r_len, r_g, 1'b1, 64'h0, 8'h00, 1'b1);
                    if (r_g) r_good_sent++; else r_bad_sent++;
                end
                r_done = 1'b1;
            end
            begin
                r_budget = 0; r_prev_stall = 1'b0;
                while (!(r_done && exp_q.size() == 0) && r_budget < 60000) begin
                    r_expv = exp_q.size() > 0 && exp_q[0].c + 2 <= cyc;
                    checks++; if (o_tvalid !== r_expv) begin fails++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, o_tvalid, r_expv); end
                    if (r_expv) begin
                        checks++; if (o_beat !== exp_q[0].b) begin fails++; $display("FAIL rand_beat cyc %0d: got %h want %h", cyc, o_beat, exp_q[0].b); end
                    end
                    if (r_prev_stall) begin
                        checks++; if (o_tvalid !== 1'b1 || o_beat !== r_prev_beat) begin fails++; $display("FAIL rand_hold cyc %0d: got v=%b %h want v=1 %h", cyc, o_tvalid, o_beat, r_prev_beat); end
                    end
                    m_tready = 1'($urandom);
                    r_prev_stall = o_tvalid && !m_tready;
                    r_prev_beat = o_beat;
                    if (r_expv && m_tready) void'(exp_q.pop_front());
                    @(negedge clk156);
                    r_budget++;
                end
                r_stop = 1'b1;
                checks++; if (r_budget >= 60000) begin fails++; $display("FAIL rand_timeout: got %0d pending want 0", exp_q.size()); end
            end
        join
        checks++; if (o_good !== 32'(r_good_sent)) begin fails++; $display("FAIL rand_good: got %0d want %0d", o_good, r_good_sent); end
        checks++; if (o_bad !== 32'(r_bad_sent)) begin fails++; $display("FAIL rand_bad: got %0d want %0d", o_bad, r_bad_sent); end
        checks++; if (o_ovf !== 32'd0) begin fails++; $display("FAIL rand_ovf: got %0d want 0", o_ovf); end
    endtask

    task automatic test_reset_mid_output();
        logic [72:0] e;
        sel = 1'b0; m_tready = 1'b1;
        do_reset();
        send_frame(20, 1'b1, 1'b0, 64'h500, 8'hFF, 1'b0);
        rx_q.delete();
        collect(6);
        checks++; if (rx_q.size() == 0) begin fails++; $display("FAIL mid_started: got 0 beats want >0"); end
        for (int i = 0; i < rx_q.size(); i++) begin
            e = {1'b0, 8'hFF, 64'h500 + 64'(i)};
            checks++; if (rx_q[i].b !== e) begin fails++; $display("FAIL mid_beat%0d: got %h want %h", i, rx_q[i].b, e); end
        end
        reset = 1'b1;
        @(negedge clk156);
        reset = 1'b0;
        checks++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL mid_tvalid: got %b want 0", o_tvalid); end
        checks++; if (o_good !== 32'd0) begin fails++; $display("FAIL mid_good: got %0d want 0", o_good); end
        checks++; if (o_bad !== 32'd0 || o_ovf !== 32'd0) begin fails++; $display("FAIL mid_counters: got %0d/%0d want 0/0", o_bad, o_ovf); end
        rx_q.delete();
        send_frame(4, 1'b1, 1'b0, 64'h600, 8'h01, 1'b0);
        collect(12);
        checks++; if (rx_q.size() != 4) begin fails++; $display("FAIL mid_count: got %0d want 4", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 4; i++) begin
            e = {i == 3, (i == 3) ? 8'h01 : 8'hFF, 64'h600 + 64'(i)};
            checks++; if (rx_q[i].b !== e) begin fails++; $display("FAIL mid_after_beat%0d: got %h want %h", i, rx_q[i].b, e); end
        end
        checks++; if (o_good !== 32'd1) begin fails++; $display("FAIL mid_after_good: got %0d want 1", o_good); end
    endtask

    initial begin
        reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        s_tdata = '0; s_tkeep = '0; m_tready = 1'b0; sel = 1'b0;
        @(negedge clk156);
        test_reset();
        test_good_frame();
        test_bad_then_good();
        test_overflow();
        test_long_frame();
        test_random();
        test_reset_mid_output();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion want finish before %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
